// File: rtl/pcm_i2s_tx_if.sv
// Sample stream from the mixer into the I2S transmitter: data, valid and ready.
interface pcm_i2s_tx_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] pcm;
    logic                  pcm_valid;
    logic                  pcm_ready;

    modport master (output pcm, output pcm_valid, input pcm_ready);
    modport slave  (input pcm, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pcm_i2s_tx.sv
// I2S transmitter: buffers mono PCM samples and sends each on both slots, MSB first,
// with bit and word clocks derived from the system clock.
module pcm_i2s_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    pcm_i2s_tx_if.slave                     pcm_in,
    input  logic                            underflow_clr,
    output logic                            bclk,
    output logic                            lrck,
    output logic                            sdata,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BitLast = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SlotLen = BIT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DIV_W-1:0]      div_cnt, div_cnt_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt, slot_k;
    logic [DATA_WIDTH-1:0] sample_q, sample_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  bclk_nxt, lrck_nxt, sdata_nxt, underflow_nxt, ready_nxt;
    logic                  fall_ev, frame_start, do_write, do_pop;

    always_comb begin
        div_cnt_nxt   = div_cnt + 1'b1;
        bclk_nxt      = bclk;
        bit_cnt_nxt   = bit_cnt;
        lrck_nxt      = lrck;
        sdata_nxt     = sdata;
        sample_nxt    = sample_q;
        underflow_nxt = underflow;
        count_nxt     = fifo_count;
        fall_ev       = 1'b0;
        slot_k        = '0;

        if (div_cnt == DivLast) begin
            div_cnt_nxt = '0;
            bclk_nxt    = ~bclk;
            fall_ev     = bclk;
        end

        if (fall_ev) begin
            bit_cnt_nxt = (bit_cnt == BitLast) ? '0 : bit_cnt + 1'b1;
        end
        frame_start = fall_ev && (bit_cnt_nxt == '0);

        do_write = pcm_in.pcm_valid && pcm_in.pcm_ready;
        do_pop   = frame_start && (fifo_count != '0);

        if (fall_ev) begin
            lrck_nxt  = (bit_cnt_nxt >= SlotLen);
            slot_k    = lrck_nxt ? bit_cnt_nxt - SlotLen : bit_cnt_nxt;
            // k=0 is the I2S delay bit; bits past the sample width are padded with zero
            sdata_nxt = 1'b0;
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                if (int'(slot_k) == int'(DATA_WIDTH) - i) sdata_nxt = sample_q[i];
            end
        end

        if (frame_start) begin
            sample_nxt = do_pop ? mem[rd_ptr] : '0;
        end

        if (frame_start && !do_pop) begin
            underflow_nxt = 1'b1;
        end else if (underflow_clr) begin
            underflow_nxt = 1'b0;
        end

        case ({do_write, do_pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
        ready_nxt = (count_nxt != CntFull);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt          <= '0;
            bclk             <= 1'b0;
            bit_cnt          <= BitLast;
            lrck             <= 1'b1;
            sdata            <= 1'b0;
            sample_q         <= '0;
            underflow        <= 1'b0;
            fifo_count       <= '0;
            pcm_in.pcm_ready <= 1'b1;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
        end else begin
            div_cnt          <= div_cnt_nxt;
            bclk             <= bclk_nxt;
            bit_cnt          <= bit_cnt_nxt;
            lrck             <= lrck_nxt;
            sdata            <= sdata_nxt;
            sample_q         <= sample_nxt;
            underflow        <= underflow_nxt;
            fifo_count       <= count_nxt;
            pcm_in.pcm_ready <= ready_nxt;
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr] <= pcm_in.pcm;
    end
endmodule

// File: doc/pcm_i2s_tx.md
Name: pcm_i2s_tx

Overview:
- Output-side consumer of the mixed 24-bit `pcm` stream produced by the sound machine.
- Buffers samples in a small FIFO and generates the codec serial clocks: bit clock `bclk` and word clock `lrck`, both derived from the system clock.
- Serializes each sample MSB-first in I2S format to the DAC data pin. The same mono sample goes to the left and right slots.
- Reports underflow when the producer fails to supply a sample by frame start.

Parameters:
- CLK_DIV, 4: system clocks per half bclk period; must be ≥2.
- DATA_WIDTH, 24: sample width in bits.
- SLOT_BITS, 32: bclk periods per channel slot; must be ≥ DATA_WIDTH+1.
- FIFO_DEPTH, 4: sample buffer entries; must be a power of 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pcm  input  DATA_WIDTH  sample to enqueue; two's-complement, passed through unmodified.
- pcm_valid  input  1  `pcm` holds a sample this cycle.
- pcm_ready  output  1  FIFO can accept a sample; equals NOT full.
- underflow_clr  input  1  clears the sticky underflow flag.
- bclk  output  1  codec bit clock.
- lrck  output  1  codec word clock; 0 = left slot, 1 = right slot.
- sdata  output  1  serial data to the codec DAC.
- underflow  output  1  sticky; set when a frame starts with the FIFO empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of samples currently buffered.

Behaviour:
- Reset (async, active-high), all outputs registered. Reset values:
  - bclk=0, lrck=1, sdata=0, underflow=0, fifo_count=0, pcm_ready=1.
  - bit_cnt=2*SLOT_BITS-1, div_cnt=0; FIFO pointers cleared; shift register=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1: bclk toggles and div_cnt returns to 0.
  - A "fall event" is a cycle in which bclk toggles 1→0. A "rise event" is a toggle 0→1.
- Bit counter: on each fall event, bit_cnt increments modulo 2*SLOT_BITS.
- Frame start is the fall event where bit_cnt wraps to 0.
  - The first frame start follows 2*CLK_DIV rising clock edges after reset deasserts.
- lrck updates on fall events only:
  - lrck=0 while the new bit_cnt < SLOT_BITS, else lrck=1.
  - It therefore changes together with the first bit of each slot.
- sdata updates on fall events only, so the codec samples it on bclk rise. With k = bit_cnt mod SLOT_BITS:
  - k=0: sdata=0 (the I2S one-bit delay).
  - 1≤k≤DATA_WIDTH: sdata = sample[DATA_WIDTH-k] (MSB first).
  - k>DATA_WIDTH: sdata=0.
  - Both slots carry the same latched sample.
- Sample fetch at frame start:
  - FIFO non-empty: pop the head into the shift register. fifo_count decrements that cycle unless a write also occurs.
  - FIFO empty: load zero and set underflow=1.
  - The sample is held for the whole frame; it is never re-fetched mid-frame.
- Write handshake:
  - A write occurs on a clock edge with pcm_valid && pcm_ready; the sample is stored at the tail.
  - Writes are accepted in any cycle, independent of bclk phase.
  - When full, pcm_ready=0 and pcm is ignored.
- Simultaneous write and pop:
  - Both occur; fifo_count is unchanged; ordering is preserved.
  - If the FIFO is empty at the same edge as a frame start, the pop sees empty: zero is sent and underflow is set. The written sample is stored and is used at the next frame start.
  - If full, a pop in the same cycle does not make pcm_ready high in that cycle; ready rises the next cycle.
- underflow:
  - Sticky until underflow_clr=1 (synchronous clear) or reset.
  - If clear and a new underflow event coincide, the set wins.
- Latency: a sample written into an empty FIFO appears on sdata at the first bit of the next frame; its MSB is at k=1.
- Reset mid-frame: outputs return to their reset values immediately. Buffered samples are discarded, and the divider and framing restart from the reset state.
- Width/bit rate: bclk period = 2*CLK_DIV clocks; frame = 2*SLOT_BITS bclk periods. No arithmetic on the data.

Test Plan:
- Reset release, no writes (CLK_DIV=4) -> bclk first rises at edge 4 and falls at edge 8. lrck=0 from edge 8. sdata stays 0 for the whole frame. underflow=1 after edge 8.
- Write 24'hA5A5A5 before the first frame start -> left slot: k=0 is 0, k=1..24 is 101001011010010110100101, k=25..31 is 0. The right slot is identical with lrck=1. fifo_count 1→0 at frame start.
- Write 5 samples back-to-back with pcm_valid held high from reset -> fifo_count reaches 4, pcm_ready=0 at count 4, the 5th sample is not accepted. After the next frame start: count=3 and pcm_ready=1.
- underflow set by an empty frame, then pulse underflow_clr with a sample buffered -> underflow=0 and stays 0 across the next frame; the sample is serialized correctly.
- Write exactly at a frame-start edge with the FIFO empty -> zero frame sent, underflow=1, fifo_count=1. That sample is sent in the following frame.
- Assert reset mid-right-slot with 2 samples buffered -> bclk=0, lrck=1, sdata=0, fifo_count=0 immediately. After release, timing restarts exactly as in the first scenario.
